// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory fill responder.
// FSM encoding, counter width, default fill pattern and small helper functions.
// No logic of its own; imported by the responder top level.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int COUNT_WIDTH = 16;
    localparam logic [31:0] DEFAULT_FILL_PATTERN = 32'h3F3;

    function automatic int clog2(input int unsigned value);
        int          bits;
        int unsigned rem;
        bits = 0;
        if (value > 1) begin
            rem = value - 1;
            while (rem > 0) begin
                bits = bits + 1;
                rem  = rem >> 1;
            end
        end
        return bits;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (value == '1) ? value : value + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mem_model_array.sv
// Word-addressed backing store, pattern-initialised on reset; with MEM_WRITE_EN undefined it is a pattern ROM.
// Latency: one cycle, rdata updates on the edge where en is high (writes echo wdata).
// Backpressure: none; rdata holds its value whenever en is low.
module mem_model_array #(
    parameter int                    ADDR_WIDTH   = 11,
    parameter int                    DATA_WIDTH   = 11,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Only the low DATA_WIDTH address bits take part in the pattern.
    function automatic logic [DATA_WIDTH-1:0] fill_word(input logic [31:0] word_addr);
        return DATA_WIDTH'(word_addr) ^ FILL_PATTERN;
    endfunction

`ifdef MEM_WRITE_EN
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= fill_word(32'(i));
            end
            rdata <= '0;
        end else if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
`else
    logic unused_write_path;
    assign unused_write_path = &{1'b0, we, wdata};

    // Contents can never change, so the pattern is computed instead of stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= fill_word(32'(addr));
        end
    end
`endif

endmodule

// File: rtl/mem_fill_responder.sv
// Backing-memory responder for cache fills and write-backs; write path compiled in only with MEM_WRITE_EN.
// Latency: acceptance at edge T gives resp_valid from edge T+LATENCY; one request outstanding.
// Backpressure: resp_valid/resp_data held until resp_ready; req_ready low from acceptance until the handshake.
module mem_fill_responder
    import mem_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 11,
    parameter int                    DATA_WIDTH   = 11,
    parameter int                    LATENCY      = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = DATA_WIDTH'(DEFAULT_FILL_PATTERN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   req_write,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic [COUNT_WIDTH-1:0] read_count,
    output logic [COUNT_WIDTH-1:0] write_count
);

    localparam int LAT_W = clog2(LATENCY + 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    req_t             req_buf;
    req_t             req_in;
    logic             accept;
    logic             resp_done;
    logic             lat_done;
    logic             mem_en;

    assign accept    = req_valid && req_ready;
    assign resp_done = resp_valid && resp_ready;
    assign lat_done  = (lat_cnt == '0);

`ifdef MEM_WRITE_EN
    assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};
`else
    logic unused_req_write;
    assign unused_req_write = &{1'b0, req_write, req_wdata};
    assign req_in = '{write: 1'b0, addr: req_addr, wdata: '0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)  state_nxt = WAIT;
            WAIT:    if (lat_done)   state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // The array access is issued on the WAIT->RESP edge, so its registered
    // output lands exactly when resp_valid rises and stays put through RESP.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        case (state)
            IDLE:    req_ready  = 1'b1;
            WAIT:    mem_en     = lat_done;
            RESP:    resp_valid = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_buf <= '0;
            lat_cnt <= '0;
        end else if (accept) begin
            req_buf <= req_in;
            lat_cnt <= LAT_W'(LATENCY - 1);
        end else if (state == WAIT && !lat_done) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_count <= '0;
        end else if (resp_done && !req_buf.write) begin
            read_count <= sat_inc(read_count);
        end
    end

`ifdef MEM_WRITE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_count <= '0;
        end else if (resp_done && req_buf.write) begin
            write_count <= sat_inc(write_count);
        end
    end
`else
    assign write_count = '0;
`endif

    mem_model_array #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .FILL_PATTERN (FILL_PATTERN)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (req_buf.write),
        .addr  (req_buf.addr),
        .wdata (req_buf.wdata),
        .rdata (resp_data)
    );

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench: instance a runs LATENCY=4, instance b runs LATENCY=1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_fill_responder;

    logic clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready;
    logic [10:0] a_req_addr, a_req_wdata, a_resp_data;
    logic [15:0] a_read_count, a_write_count;

    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready;
    logic [10:0] b_req_addr, b_req_wdata, b_resp_data;
    logic [15:0] b_read_count, b_write_count;

    int checks = 0;
    int passes = 0;

`ifdef MEM_WRITE_EN
    localparam logic [10:0] EXP_WR_DATA = 11'h123;
    localparam logic [15:0] EXP_WR_CNT  = 16'd1;
    localparam logic [15:0] EXP_RD_CNT  = 16'd4;
`else
    localparam logic [10:0] EXP_WR_DATA = 11'h3E3;
    localparam logic [15:0] EXP_WR_CNT  = 16'd0;
    localparam logic [15:0] EXP_RD_CNT  = 16'd5;
`endif

    mem_fill_responder #(.ADDR_WIDTH(11), .DATA_WIDTH(11), .LATENCY(4), .FILL_PATTERN(11'h3F3)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_write(a_req_write), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
        .read_count(a_read_count), .write_count(a_write_count)
    );

    mem_fill_responder #(.ADDR_WIDTH(11), .DATA_WIDTH(11), .LATENCY(1), .FILL_PATTERN(11'h3F3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_write(b_req_write), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .read_count(b_read_count), .write_count(b_write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge with dut_a idle; lat = edges after acceptance until resp_valid.
    task automatic issue_a(input logic [10:0] addr, input logic wr, input logic [10:0] wd, output int lat);
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        a_req_write = wr;
        a_req_wdata = wd;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
        lat = 0;
        while (a_resp_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic complete_a();
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", a_req_ready); else passes++;
        checks++; if (a_resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", a_resp_valid); else passes++;
        checks++; if (a_resp_data !== 11'h000) $display("FAIL rst_resp_data: got %h expected 000", a_resp_data); else passes++;
        checks++; if (a_read_count !== 16'd0) $display("FAIL rst_read_count: got %0d expected 0", a_read_count); else passes++;
        checks++; if (a_write_count !== 16'd0) $display("FAIL rst_write_count: got %0d expected 0", a_write_count); else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_req_ready !== 1'b1) $display("FAIL post_rst_req_ready: got %b expected 1", a_req_ready); else passes++;
    endtask

    task automatic test_read();
        int lat;
        issue_a(11'h005, 1'b0, 11'h000, lat);
        checks++; if (lat !== 4) $display("FAIL read_latency: got %0d expected 4", lat); else passes++;
        checks++; if (a_resp_data !== 11'h3F6) $display("FAIL read_data: got %h expected 3f6", a_resp_data); else passes++;
        complete_a();
        checks++; if (a_read_count !== 16'd1) $display("FAIL read_count: got %0d expected 1", a_read_count); else passes++;
        checks++; if (a_resp_valid !== 1'b0) $display("FAIL read_resp_drop: got %b expected 0", a_resp_valid); else passes++;
        checks++; if (a_req_ready !== 1'b1) $display("FAIL read_req_ready: got %b expected 1", a_req_ready); else passes++;
    endtask

    task automatic test_back_pressure();
        int lat;
        issue_a(11'h005, 1'b0, 11'h000, lat);
        checks++; if (lat !== 4) $display("FAIL bp_latency: got %0d expected 4", lat); else passes++;
        // A competing request sits on the inputs while the response is stalled.
        a_req_valid = 1'b1;
        a_req_addr  = 11'h007;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_resp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, a_resp_valid); else passes++;
            checks++; if (a_resp_data !== 11'h3F6) $display("FAIL bp_hold_data[%0d]: got %h expected 3f6", i, a_resp_data); else passes++;
            checks++; if (a_req_ready !== 1'b0) $display("FAIL bp_hold_req_ready[%0d]: got %b expected 0", i, a_req_ready); else passes++;
        end
        complete_a();
        checks++; if (a_resp_valid !== 1'b0) $display("FAIL bp_resp_drop: got %b expected 0", a_resp_valid); else passes++;
        checks++; if (a_req_ready !== 1'b1) $display("FAIL bp_req_ready_after: got %b expected 1", a_req_ready); else passes++;
        checks++; if (a_read_count !== 16'd2) $display("FAIL bp_read_count: got %0d expected 2", a_read_count); else passes++;
        @(negedge clk);
        a_req_valid = 1'b0;
        checks++; if (a_req_ready !== 1'b0) $display("FAIL bp_second_accept: got req_ready %b expected 0", a_req_ready); else passes++;
        lat = 0;
        while (a_resp_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 4) $display("FAIL bp_second_latency: got %0d expected 4", lat); else passes++;
        checks++; if (a_resp_data !== 11'h3F4) $display("FAIL bp_second_data: got %h expected 3f4", a_resp_data); else passes++;
        complete_a();
    endtask

    task automatic test_write_read();
        int lat;
        issue_a(11'h010, 1'b1, 11'h123, lat);
        checks++; if (lat !== 4) $display("FAIL wr_latency: got %0d expected 4", lat); else passes++;
        checks++; if (a_resp_data !== EXP_WR_DATA) $display("FAIL wr_echo: got %h expected %h", a_resp_data, EXP_WR_DATA); else passes++;
        complete_a();
        issue_a(11'h010, 1'b0, 11'h000, lat);
        checks++; if (a_resp_data !== EXP_WR_DATA) $display("FAIL wr_readback: got %h expected %h", a_resp_data, EXP_WR_DATA); else passes++;
        complete_a();
        checks++; if (a_write_count !== EXP_WR_CNT) $display("FAIL wr_write_count: got %0d expected %0d", a_write_count, EXP_WR_CNT); else passes++;
        checks++; if (a_read_count !== EXP_RD_CNT) $display("FAIL wr_read_count: got %0d expected %0d", a_read_count, EXP_RD_CNT); else passes++;
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        int seen;
        a_req_valid = 1'b1;
        a_req_addr  = 11'h005;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (a_resp_valid !== 1'b0) $display("FAIL mid_rst_resp_valid: got %b expected 0", a_resp_valid); else passes++;
        checks++; if (a_req_ready !== 1'b1) $display("FAIL mid_rst_req_ready: got %b expected 1", a_req_ready); else passes++;
        checks++; if (a_resp_data !== 11'h000) $display("FAIL mid_rst_resp_data: got %h expected 000", a_resp_data); else passes++;
        checks++; if (a_read_count !== 16'd0) $display("FAIL mid_rst_read_count: got %0d expected 0", a_read_count); else passes++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_resp_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL mid_rst_discard: got %0d response cycles expected 0", seen); else passes++;
        issue_a(11'h005, 1'b0, 11'h000, lat);
        checks++; if (lat !== 4) $display("FAIL mid_rst_latency: got %0d expected 4", lat); else passes++;
        checks++; if (a_resp_data !== 11'h3F6) $display("FAIL mid_rst_data: got %h expected 3f6", a_resp_data); else passes++;
        complete_a();
        // Reset restores the pattern even where an earlier write landed.
        issue_a(11'h010, 1'b0, 11'h000, lat);
        checks++; if (a_resp_data !== 11'h3E3) $display("FAIL mid_rst_reinit: got %h expected 3e3", a_resp_data); else passes++;
        complete_a();
        checks++; if (a_read_count !== 16'd2) $display("FAIL mid_rst_read_count_after: got %0d expected 2", a_read_count); else passes++;
    endtask

    // Accept at T, resp_valid from T+1, handshake at T+2, next accept at T+3.
    task automatic test_back_to_back();
        int          cyc;
        int          acc_n;
        int          rsp_n;
        int          acc_cyc [2];
        logic [10:0] rsp_dat [2];
        cyc   = 0;
        acc_n = 0;
        rsp_n = 0;
        acc_cyc = '{0, 0};
        rsp_dat = '{11'h0, 11'h0};
        b_req_valid  = 1'b1;
        b_req_addr   = 11'h000;
        b_resp_ready = 1'b1;
        while (rsp_n < 2 && cyc < 20) begin
            if (b_req_valid === 1'b1 && b_req_ready === 1'b1 && acc_n < 2) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            if (b_resp_valid === 1'b1 && rsp_n < 2) begin
                rsp_dat[rsp_n] = b_resp_data;
                rsp_n++;
            end
            @(negedge clk);
            cyc++;
            if (acc_n == 1) b_req_addr = 11'h001;
            if (acc_n >= 2) b_req_valid = 1'b0;
        end
        @(negedge clk);
        b_resp_ready = 1'b0;
        checks++; if (acc_n !== 2) $display("FAIL b2b_accepts: got %0d expected 2", acc_n); else passes++;
        checks++; if (rsp_n !== 2) $display("FAIL b2b_responses: got %0d expected 2", rsp_n); else passes++;
        checks++; if (rsp_dat[0] !== 11'h3F3) $display("FAIL b2b_data0: got %h expected 3f3", rsp_dat[0]); else passes++;
        checks++; if (rsp_dat[1] !== 11'h3F2) $display("FAIL b2b_data1: got %h expected 3f2", rsp_dat[1]); else passes++;
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 3) $display("FAIL b2b_spacing: got %0d expected 3", acc_cyc[1] - acc_cyc[0]); else passes++;
        checks++; if (b_read_count !== 16'd2) $display("FAIL b2b_read_count: got %0d expected 2", b_read_count); else passes++;
        checks++; if (b_resp_valid !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", b_resp_valid); else passes++;
    endtask

    initial begin
        rst          = 1'b1;
        a_req_valid  = 1'b0;
        a_req_addr   = '0;
        a_req_write  = 1'b0;
        a_req_wdata  = '0;
        a_resp_ready = 1'b0;
        b_req_valid  = 1'b0;
        b_req_addr   = '0;
        b_req_write  = 1'b0;
        b_req_wdata  = '0;
        b_resp_ready = 1'b0;
        test_reset();
        test_read();
        test_back_pressure();
        test_write_read();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
